// File: rtl/adder_tree_pkg.sv
// Shared helpers for the adder-tree slice: index sizing for term vectors.
package adder_tree_pkg;

    // Index width for n slots; never narrower than one bit so n=1 still has a counter.
    function automatic int unsigned term_idx_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_adder_tree_term_packer.sv
// Packs a serial term stream into zero-padded NUM_ELEMENTS-wide vectors for the adder tree.
// Optional sticky protocol-error output o_err when PIPE_ADDER_TREE_TERM_PACKER_ERR_EN is defined.
module pipe_adder_tree_term_packer
    import adder_tree_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS = 4,
    parameter int unsigned BIT_LEN      = 16,
    parameter int unsigned CTL_BITS     = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [BIT_LEN-1:0]  i_dat,
    input  logic [CTL_BITS-1:0] i_ctl,
    input  logic                i_val,
    input  logic                i_sop,
    input  logic                i_eop,
    output logic                o_rdy,
    output logic [BIT_LEN-1:0]  o_terms [NUM_ELEMENTS],
    output logic [CTL_BITS-1:0] o_ctl,
    output logic                o_val,
    output logic                o_sop,
    output logic                o_eop,
`ifdef PIPE_ADDER_TREE_TERM_PACKER_ERR_EN
    output logic                o_err,
`endif
    input  logic                i_rdy
);

    localparam int unsigned IW = term_idx_bits(NUM_ELEMENTS);

    typedef logic [BIT_LEN-1:0] term_t;
    typedef struct packed {
        logic [CTL_BITS-1:0] ctl;
        logic                sop;
        logic                eop;
    } sband_t;

    term_t         fill_q [NUM_ELEMENTS];
    term_t         fill_d [NUM_ELEMENTS];
    term_t         out_q  [NUM_ELEMENTS];
    term_t         out_d  [NUM_ELEMENTS];
    term_t         grp    [NUM_ELEMENTS];
    logic [IW-1:0] idx_q, idx_d, slot;
    logic          pend_q, pend_d;
    sband_t        pend_sb_q, pend_sb_d;
    sband_t        out_sb_q, out_sb_d;
    sband_t        grp_sb;
    logic          out_val_q, out_val_d;
    logic          first_q, first_d;
    logic [CTL_BITS-1:0] ctl_q, ctl_d;
    logic          accept, complete, out_free;
`ifdef PIPE_ADDER_TREE_TERM_PACKER_ERR_EN
    logic          in_pkt_q, in_pkt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        fill_d    = fill_q;
        out_d     = out_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        pend_sb_d = pend_sb_q;
        out_sb_d  = out_sb_q;
        out_val_d = out_val_q;
        first_d   = first_q;
        ctl_d     = ctl_q;
`ifdef PIPE_ADDER_TREE_TERM_PACKER_ERR_EN
        in_pkt_d  = in_pkt_q;
        err_d     = err_q;
`endif
        // o_rdy is !pend_q, so no beat is taken while a group is held.
        accept   = i_val && !pend_q;
        out_free = !out_val_q || i_rdy;
        slot     = i_sop ? '0 : idx_q;
        complete = (slot == IW'(NUM_ELEMENTS - 1)) || i_eop;
        grp_sb.ctl = i_sop ? i_ctl : ctl_q;
        grp_sb.sop = i_sop || first_q;
        grp_sb.eop = i_eop;
        for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
            if (IW'(i) < slot)       grp[i] = fill_q[i];
            else if (IW'(i) == slot) grp[i] = i_dat;
            else                     grp[i] = '0;
        end

        if (out_val_q && i_rdy) out_val_d = 1'b0;

        if (pend_q) begin
            if (i_rdy) begin
                out_d     = fill_q;
                out_sb_d  = pend_sb_q;
                out_val_d = 1'b1;
                pend_d    = 1'b0;
            end
        end else if (accept) begin
            ctl_d  = grp_sb.ctl;
            fill_d = grp;
`ifdef PIPE_ADDER_TREE_TERM_PACKER_ERR_EN
            if ((i_sop && idx_q != '0) || (!i_sop && !in_pkt_q)) err_d = 1'b1;
            in_pkt_d = !i_eop;
`endif
            if (complete) begin
                idx_d   = '0;
                first_d = 1'b0;
                if (out_free) begin
                    out_d     = grp;
                    out_sb_d  = grp_sb;
                    out_val_d = 1'b1;
                end else begin
                    pend_sb_d = grp_sb;
                    pend_d    = 1'b1;
                end
            end else begin
                idx_d   = slot + IW'(1);
                first_d = grp_sb.sop;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fill_q    <= '{default: '0};
            out_q     <= '{default: '0};
            idx_q     <= '0;
            pend_q    <= 1'b0;
            pend_sb_q <= '0;
            out_sb_q  <= '0;
            out_val_q <= 1'b0;
            first_q   <= 1'b0;
            ctl_q     <= '0;
`ifdef PIPE_ADDER_TREE_TERM_PACKER_ERR_EN
            in_pkt_q  <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            fill_q    <= fill_d;
            out_q     <= out_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            pend_sb_q <= pend_sb_d;
            out_sb_q  <= out_sb_d;
            out_val_q <= out_val_d;
            first_q   <= first_d;
            ctl_q     <= ctl_d;
`ifdef PIPE_ADDER_TREE_TERM_PACKER_ERR_EN
            in_pkt_q  <= in_pkt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign o_rdy   = !pend_q;
    assign o_terms = out_q;
    assign o_ctl   = out_sb_q.ctl;
    assign o_sop   = out_sb_q.sop;
    assign o_eop   = out_sb_q.eop;
    assign o_val   = out_val_q;
`ifdef PIPE_ADDER_TREE_TERM_PACKER_ERR_EN
    assign o_err   = err_q;
`endif

endmodule

// File: tb/tb_pipe_adder_tree_term_packer.sv
// Cycle-accurate directed bench for pipe_adder_tree_term_packer (NUM_ELEMENTS=4, BIT_LEN=16, CTL_BITS=8).
module tb_pipe_adder_tree_term_packer;

    logic        clk = 1'b0;
    logic        rst, val, sop, eop, rdy;
    logic [15:0] dat;
    logic [7:0]  ctl;
    logic        o_rdy, o_val, o_sop, o_eop;
    logic [15:0] o_terms [4];
    logic [7:0]  o_ctl;
`ifdef PIPE_ADDER_TREE_TERM_PACKER_ERR_EN
    logic        o_err;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_adder_tree_term_packer #(.NUM_ELEMENTS(4), .BIT_LEN(16), .CTL_BITS(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_ctl(ctl), .i_val(val),
        .i_sop(sop), .i_eop(eop), .o_rdy(o_rdy), .o_terms(o_terms), .o_ctl(o_ctl),
        .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop),
`ifdef PIPE_ADDER_TREE_TERM_PACKER_ERR_EN
        .o_err(o_err),
`endif
        .i_rdy(rdy)
    );

    typedef struct {
        logic        rst, val, sop, eop, rdy;
        logic [15:0] dat;
        logic [7:0]  ctl;
        logic        e_val, e_sop, e_eop, e_rdy;
        logic [15:0] e_t [4];
        logic [7:0]  e_ctl;
    } row_t;

    row_t rows[$];

    function automatic row_t nov(logic r, logic v, logic s, logic e, logic [15:0] d,
                                 logic [7:0] c, logic dr, logic erdy);
        row_t x;
        x.rst = r; x.val = v; x.sop = s; x.eop = e; x.dat = d; x.ctl = c; x.rdy = dr;
        x.e_val = 1'b0; x.e_sop = 1'b0; x.e_eop = 1'b0; x.e_rdy = erdy;
        x.e_t = '{default: '0}; x.e_ctl = '0;
        return x;
    endfunction

    function automatic row_t vec(logic v, logic s, logic e, logic [15:0] d, logic [7:0] c,
                                 logic dr, logic erdy, logic es, logic ee,
                                 logic [15:0] t0, logic [15:0] t1, logic [15:0] t2,
                                 logic [15:0] t3, logic [7:0] ec);
        row_t x;
        x = nov(1'b0, v, s, e, d, c, dr, erdy);
        x.e_val = 1'b1; x.e_sop = es; x.e_eop = ee;
        x.e_t[0] = t0; x.e_t[1] = t1; x.e_t[2] = t2; x.e_t[3] = t3; x.e_ctl = ec;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input row_t r, input int id);
        rst = r.rst; val = r.val; sop = r.sop; eop = r.eop;
        dat = r.dat; ctl = r.ctl; rdy = r.rdy;
        @(posedge clk);
        #1;
        chk($sformatf("row%0d o_val", id), 32'(o_val), 32'(r.e_val));
        chk($sformatf("row%0d o_rdy", id), 32'(o_rdy), 32'(r.e_rdy));
        if (r.e_val) begin
            chk($sformatf("row%0d o_sop", id), 32'(o_sop), 32'(r.e_sop));
            chk($sformatf("row%0d o_eop", id), 32'(o_eop), 32'(r.e_eop));
            chk($sformatf("row%0d o_ctl", id), 32'(o_ctl), 32'(r.e_ctl));
            for (int k = 0; k < 4; k++)
                chk($sformatf("row%0d term%0d", id, k), 32'(o_terms[k]), 32'(r.e_t[k]));
        end
    endtask

    initial begin
        rst = 1'b1; val = 1'b0; sop = 1'b0; eop = 1'b0; rdy = 1'b1; dat = '0; ctl = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset o_val", 32'(o_val), 32'd0);
        chk("reset o_sop", 32'(o_sop), 32'd0);
        chk("reset o_eop", 32'(o_eop), 32'd0);
        chk("reset o_rdy", 32'(o_rdy), 32'd1);
        chk("reset o_ctl", 32'(o_ctl), 32'd0);
        for (int k = 0; k < 4; k++) chk($sformatf("reset term%0d", k), 32'(o_terms[k]), 32'd0);
`ifdef PIPE_ADDER_TREE_TERM_PACKER_ERR_EN
        chk("reset o_err", 32'(o_err), 32'd0);
`endif

        // 8-beat packet, two full vectors
        rows.push_back(nov(0, 1, 1, 0, 16'd1, 8'h5A, 1, 1));
        rows.push_back(nov(0, 1, 0, 0, 16'd2, 8'h00, 1, 1));
        rows.push_back(nov(0, 1, 0, 0, 16'd3, 8'h00, 1, 1));
        rows.push_back(vec(1, 0, 0, 16'd4, 8'h00, 1, 1, 1, 0, 16'd1, 16'd2, 16'd3, 16'd4, 8'h5A));
        rows.push_back(nov(0, 1, 0, 0, 16'd5, 8'h00, 1, 1));
        rows.push_back(nov(0, 1, 0, 0, 16'd6, 8'h00, 1, 1));
        rows.push_back(nov(0, 1, 0, 0, 16'd7, 8'h00, 1, 1));
        rows.push_back(vec(1, 0, 1, 16'd8, 8'h00, 1, 1, 0, 1, 16'd5, 16'd6, 16'd7, 16'd8, 8'h5A));
        // 6-beat packet, padded tail, no third vector
        rows.push_back(nov(0, 1, 1, 0, 16'd10, 8'h33, 1, 1));
        rows.push_back(nov(0, 1, 0, 0, 16'd11, 8'h00, 1, 1));
        rows.push_back(nov(0, 1, 0, 0, 16'd12, 8'h00, 1, 1));
        rows.push_back(vec(1, 0, 0, 16'd13, 8'h00, 1, 1, 1, 0, 16'd10, 16'd11, 16'd12, 16'd13, 8'h33));
        rows.push_back(nov(0, 1, 0, 0, 16'd14, 8'h00, 1, 1));
        rows.push_back(vec(1, 0, 1, 16'd15, 8'h00, 1, 1, 0, 1, 16'd14, 16'd15, 16'd0, 16'd0, 8'h33));
        rows.push_back(nov(0, 0, 0, 0, 16'd0, 8'h00, 1, 1));
        rows.push_back(nov(0, 0, 0, 0, 16'd0, 8'h00, 1, 1));
        // single sop+eop beat
        rows.push_back(vec(1, 1, 1, 16'h1234, 8'hC3, 1, 1, 1, 1, 16'h1234, 16'd0, 16'd0, 16'd0, 8'hC3));
        rows.push_back(nov(0, 0, 0, 0, 16'd0, 8'h00, 1, 1));
        // back-pressure: i_rdy low for 10 cycles during a 12-beat stream
        rows.push_back(nov(0, 1, 1, 0, 16'd21, 8'h77, 0, 1));
        rows.push_back(nov(0, 1, 0, 0, 16'd22, 8'h00, 0, 1));
        rows.push_back(nov(0, 1, 0, 0, 16'd23, 8'h00, 0, 1));
        rows.push_back(vec(1, 0, 0, 16'd24, 8'h00, 0, 1, 1, 0, 16'd21, 16'd22, 16'd23, 16'd24, 8'h77));
        rows.push_back(vec(1, 0, 0, 16'd25, 8'h00, 0, 1, 1, 0, 16'd21, 16'd22, 16'd23, 16'd24, 8'h77));
        rows.push_back(vec(1, 0, 0, 16'd26, 8'h00, 0, 1, 1, 0, 16'd21, 16'd22, 16'd23, 16'd24, 8'h77));
        rows.push_back(vec(1, 0, 0, 16'd27, 8'h00, 0, 1, 1, 0, 16'd21, 16'd22, 16'd23, 16'd24, 8'h77));
        rows.push_back(vec(1, 0, 0, 16'd28, 8'h00, 0, 0, 1, 0, 16'd21, 16'd22, 16'd23, 16'd24, 8'h77));
        rows.push_back(vec(1, 0, 0, 16'd29, 8'h00, 0, 0, 1, 0, 16'd21, 16'd22, 16'd23, 16'd24, 8'h77));
        rows.push_back(vec(1, 0, 0, 16'd29, 8'h00, 0, 0, 1, 0, 16'd21, 16'd22, 16'd23, 16'd24, 8'h77));
        rows.push_back(vec(1, 0, 0, 16'd29, 8'h00, 1, 1, 0, 0, 16'd25, 16'd26, 16'd27, 16'd28, 8'h77));
        rows.push_back(nov(0, 1, 0, 0, 16'd29, 8'h00, 1, 1));
        rows.push_back(nov(0, 1, 0, 0, 16'd30, 8'h00, 1, 1));
        rows.push_back(nov(0, 1, 0, 0, 16'd31, 8'h00, 1, 1));
        rows.push_back(vec(1, 0, 1, 16'd32, 8'h00, 1, 1, 0, 1, 16'd29, 16'd30, 16'd31, 16'd32, 8'h77));
        rows.push_back(nov(0, 0, 0, 0, 16'd0, 8'h00, 1, 1));
        // reset mid-packet, then a fresh packet
        rows.push_back(nov(0, 1, 1, 0, 16'hAA, 8'h11, 1, 1));
        rows.push_back(nov(0, 1, 0, 0, 16'hBB, 8'h00, 1, 1));
        rows.push_back(nov(1, 0, 0, 0, 16'd0, 8'h00, 1, 1));
        rows.push_back(nov(0, 1, 1, 0, 16'd7, 8'h22, 1, 1));
        rows.push_back(nov(0, 1, 0, 0, 16'd7, 8'h00, 1, 1));
        rows.push_back(nov(0, 1, 0, 0, 16'd7, 8'h00, 1, 1));
        rows.push_back(vec(1, 0, 1, 16'd7, 8'h00, 1, 1, 1, 1, 16'd7, 16'd7, 16'd7, 16'd7, 8'h22));
        rows.push_back(nov(0, 0, 0, 0, 16'd0, 8'h00, 1, 1));

        foreach (rows[i]) apply(rows[i], i);

`ifdef PIPE_ADDER_TREE_TERM_PACKER_ERR_EN
        chk("err clean after table", 32'(o_err), 32'd0);
`endif
        // sop on the 3rd beat restarts the fill with the new ctl
        apply(nov(0, 1, 1, 0, 16'd1, 8'h40, 1, 1), 100);
        apply(nov(0, 1, 0, 0, 16'd2, 8'h00, 1, 1), 101);
        apply(nov(0, 1, 1, 0, 16'd3, 8'h41, 1, 1), 102);
`ifdef PIPE_ADDER_TREE_TERM_PACKER_ERR_EN
        chk("err set on restart", 32'(o_err), 32'd1);
`endif
        apply(nov(0, 1, 0, 0, 16'd4, 8'h00, 1, 1), 103);
        apply(nov(0, 1, 0, 0, 16'd5, 8'h00, 1, 1), 104);
        apply(vec(1, 0, 1, 16'd6, 8'h00, 1, 1, 1, 1, 16'd3, 16'd4, 16'd5, 16'd6, 8'h41), 105);
        // continuation beat while idle reuses the last ctl and is not a first vector
        apply(vec(1, 0, 1, 16'd9, 8'h99, 1, 1, 0, 1, 16'd9, 16'd0, 16'd0, 16'd0, 8'h41), 106);
        apply(nov(0, 0, 0, 0, 16'd0, 8'h00, 1, 1), 107);
`ifdef PIPE_ADDER_TREE_TERM_PACKER_ERR_EN
        chk("err sticky", 32'(o_err), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
